// File: rtl/noc_adapter_pkg.sv
// Shared types and sizing helpers for the Nios message-PIO to NoC adapter.
package noc_adapter_pkg;

   localparam int unsigned NODE_W = 7;
   localparam int unsigned DATA_W = 32;

   typedef struct packed {
      logic [NODE_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } noc_pkt_t;

   // Ceiling log2, used for pointer widths at elaboration time.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned w;
      w = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < value) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push on a full FIFO is accepted
// only when a pop retires an entry in the same cycle.
module noc_sync_fifo
   import noc_adapter_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter type         T     = noc_pkt_t
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  push,
   input  T                      wr_data,
   input  logic                  pop,
   output T                      head_c,
   output logic                  full,
   output logic                  empty,
   output logic [clog2(DEPTH):0] count
);

   localparam int unsigned PTR_W = clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   T                 mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;
   logic [CNT_W-1:0] count_nxt;

   // A pop on an empty FIFO is ignored; push on full only rides on a real pop.
   always_comb begin
      pop_ok    = pop && !empty;
      push_ok   = push && (!full || pop_ok);
      count_nxt = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count_nxt;
         full  <= (count_nxt == CNT_W'(DEPTH));
         empty <= (count_nxt == '0);
      end
   end

   // Storage carries no reset; the head is only meaningful while not empty.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wr_data;
   end

   assign head_c = mem[rd_ptr];

endmodule

// File: rtl/nios_noc_adapter.sv
// Bridges the Nios message PIOs to one NoC port: toggle-triggered TX, FIFO-buffered RX.
// Optional drop counters are enabled with `define NOC_ADAPTER_STATS_EN.
module nios_noc_adapter
   import noc_adapter_pkg::*;
#(
   parameter int unsigned RX_DEPTH = 8,
   parameter int unsigned TX_DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [7:0]        pio_send_addr,
   input  logic [DATA_W-1:0] pio_send_data,
   output logic [7:0]        pio_recv_addr,
   output logic [DATA_W-1:0] pio_recv_data,
   input  logic              pio_ack,
   output logic [NODE_W-1:0] noc_tx_addr,
   output logic [DATA_W-1:0] noc_tx_data,
   output logic              noc_tx_valid,
   input  logic              noc_tx_ready,
   input  logic [NODE_W-1:0] noc_rx_addr,
   input  logic [DATA_W-1:0] noc_rx_data,
   input  logic              noc_rx_valid
`ifdef NOC_ADAPTER_STATS_EN
   ,
   output logic [15:0]       rx_drop_cnt,
   output logic [15:0]       tx_drop_cnt
`endif
);

   logic     tx_tog_q;
   logic     tx_req_q;
   noc_pkt_t tx_pkt_q;
   logic     rx_vld_q;
   noc_pkt_t rx_pkt_q;
   logic     ack_q;
   logic     ack_rise_q;

   noc_pkt_t                   tx_head;
   noc_pkt_t                   rx_head;
   logic                       tx_full;
   logic                       tx_empty;
   logic                       rx_full;
   logic                       rx_empty;
   logic [clog2(TX_DEPTH):0]   tx_count;
   logic [clog2(RX_DEPTH):0]   rx_count;
   logic                       tx_pop_c;
   logic                       tx_drop_c;
   logic                       rx_drop_c;
   logic                       unused_count;

   // Input stage: toggle detect, ack edge detect and RX strobe capture.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_tog_q   <= 1'b0;
         tx_req_q   <= 1'b0;
         tx_pkt_q   <= '0;
         rx_vld_q   <= 1'b0;
         rx_pkt_q   <= '0;
         ack_q      <= 1'b0;
         ack_rise_q <= 1'b0;
      end else begin
         tx_tog_q   <= pio_send_addr[7];
         tx_req_q   <= (pio_send_addr[7] != tx_tog_q);
         tx_pkt_q   <= '{addr: pio_send_addr[NODE_W-1:0], data: pio_send_data};
         rx_vld_q   <= noc_rx_valid;
         rx_pkt_q   <= '{addr: noc_rx_addr, data: noc_rx_data};
         ack_q      <= pio_ack;
         ack_rise_q <= pio_ack && !ack_q;
      end
   end

   assign tx_pop_c = !tx_empty && noc_tx_ready;

   noc_sync_fifo #(
      .DEPTH (TX_DEPTH),
      .T     (noc_pkt_t)
   ) u_tx_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (tx_req_q),
      .wr_data (tx_pkt_q),
      .pop     (tx_pop_c),
      .head_c  (tx_head),
      .full    (tx_full),
      .empty   (tx_empty),
      .count   (tx_count)
   );

   noc_sync_fifo #(
      .DEPTH (RX_DEPTH),
      .T     (noc_pkt_t)
   ) u_rx_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (rx_vld_q),
      .wr_data (rx_pkt_q),
      .pop     (ack_rise_q),
      .head_c  (rx_head),
      .full    (rx_full),
      .empty   (rx_empty),
      .count   (rx_count)
   );

   // Heads are masked while empty so every output reads 0 out of reset.
   assign noc_tx_valid  = !tx_empty;
   assign noc_tx_addr   = tx_empty ? '0 : tx_head.addr;
   assign noc_tx_data   = tx_empty ? '0 : tx_head.data;
   assign pio_recv_addr = {!rx_empty, rx_empty ? NODE_W'(0) : rx_head.addr};
   assign pio_recv_data = rx_empty ? '0 : rx_head.data;

   // A full FIFO is never empty, so any ack edge there is a real pop.
   assign tx_drop_c = tx_req_q && tx_full && !tx_pop_c;
   assign rx_drop_c = rx_vld_q && rx_full && !ack_rise_q;

   assign unused_count = ^{tx_count, rx_count, tx_drop_c, rx_drop_c};

`ifdef NOC_ADAPTER_STATS_EN
   // Saturating drop counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_drop_cnt <= '0;
         rx_drop_cnt <= '0;
      end else begin
         if (tx_drop_c && (tx_drop_cnt != 16'hFFFF)) tx_drop_cnt <= tx_drop_cnt + 16'd1;
         if (rx_drop_c && (rx_drop_cnt != 16'hFFFF)) rx_drop_cnt <= rx_drop_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_nios_noc_adapter.sv
// Directed vector bench for nios_noc_adapter: table of per-cycle vectors plus
// hand-written backpressure, overflow, drain, full push+pop and reset sequences.
module tb_nios_noc_adapter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [7:0]  pio_send_addr;
   logic [31:0] pio_send_data;
   logic [7:0]  pio_recv_addr;
   logic [31:0] pio_recv_data;
   logic        pio_ack;
   logic [6:0]  noc_tx_addr;
   logic [31:0] noc_tx_data;
   logic        noc_tx_valid;
   logic        noc_tx_ready;
   logic [6:0]  noc_rx_addr;
   logic [31:0] noc_rx_data;
   logic        noc_rx_valid;
`ifdef NOC_ADAPTER_STATS_EN
   logic [15:0] rx_drop_cnt;
   logic [15:0] tx_drop_cnt;
`endif

   int n_vec  = 0;
   int n_miss = 0;

   nios_noc_adapter #(.RX_DEPTH(8), .TX_DEPTH(2)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .pio_send_addr (pio_send_addr),
      .pio_send_data (pio_send_data),
      .pio_recv_addr (pio_recv_addr),
      .pio_recv_data (pio_recv_data),
      .pio_ack       (pio_ack),
      .noc_tx_addr   (noc_tx_addr),
      .noc_tx_data   (noc_tx_data),
      .noc_tx_valid  (noc_tx_valid),
      .noc_tx_ready  (noc_tx_ready),
      .noc_rx_addr   (noc_rx_addr),
      .noc_rx_data   (noc_rx_data),
      .noc_rx_valid  (noc_rx_valid)
`ifdef NOC_ADAPTER_STATS_EN
      ,
      .rx_drop_cnt   (rx_drop_cnt),
      .tx_drop_cnt   (tx_drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  sa;
      logic [31:0] sd;
      logic        ack;
      logic        rxv;
      logic [6:0]  rxa;
      logic [31:0] rxd;
      logic        rdy;
      logic        etv;
      logic [6:0]  eta;
      logic [31:0] etd;
      logic [7:0]  era;
      logic [31:0] erd;
   } vec_t;

   vec_t tbl [14];

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic etv, input logic [6:0] eta,
                          input logic [31:0] etd, input logic [7:0] era, input logic [31:0] erd);
      chk({tag, ".tx_valid"},  32'(noc_tx_valid),  32'(etv));
      chk({tag, ".tx_addr"},   32'(noc_tx_addr),   32'(eta));
      chk({tag, ".tx_data"},   noc_tx_data,        etd);
      chk({tag, ".recv_addr"}, 32'(pio_recv_addr), 32'(era));
      chk({tag, ".recv_data"}, pio_recv_data,      erd);
   endtask

   task automatic ack_pulse();
      pio_ack = 1'b1;
      cyc();
      pio_ack = 1'b0;
      cyc();
   endtask

   task automatic rx_strobe(input logic [6:0] a, input logic [31:0] d);
      noc_rx_valid = 1'b1;
      noc_rx_addr  = a;
      noc_rx_data  = d;
      cyc();
      noc_rx_valid = 1'b0;
   endtask

   initial begin
      //           sa     sd            ack   rxv   rxa     rxd           rdy   etv   eta      etd           era     erd
      tbl[0]  = '{8'h00, 32'hDEADBEEF, 1'b0, 1'b0, 7'h00, 32'h00000000, 1'b1, 1'b0, 7'h00, 32'h00000000, 8'h00, 32'h00000000};
      tbl[1]  = '{8'h85, 32'hDEADBEEF, 1'b0, 1'b0, 7'h00, 32'h00000000, 1'b1, 1'b0, 7'h00, 32'h00000000, 8'h00, 32'h00000000};
      tbl[2]  = '{8'h85, 32'hDEADBEEF, 1'b0, 1'b0, 7'h00, 32'h00000000, 1'b1, 1'b1, 7'h05, 32'hDEADBEEF, 8'h00, 32'h00000000};
      tbl[3]  = '{8'h85, 32'hDEADBEEF, 1'b0, 1'b0, 7'h00, 32'h00000000, 1'b1, 1'b0, 7'h00, 32'h00000000, 8'h00, 32'h00000000};
      tbl[4]  = '{8'h85, 32'h00000000, 1'b0, 1'b1, 7'h09, 32'h11111111, 1'b1, 1'b0, 7'h00, 32'h00000000, 8'h00, 32'h00000000};
      tbl[5]  = '{8'h85, 32'h00000000, 1'b0, 1'b0, 7'h00, 32'h00000000, 1'b1, 1'b0, 7'h00, 32'h00000000, 8'h89, 32'h11111111};
      tbl[6]  = '{8'h85, 32'h00000000, 1'b1, 1'b0, 7'h00, 32'h00000000, 1'b1, 1'b0, 7'h00, 32'h00000000, 8'h89, 32'h11111111};
      tbl[7]  = '{8'h85, 32'h00000000, 1'b1, 1'b0, 7'h00, 32'h00000000, 1'b1, 1'b0, 7'h00, 32'h00000000, 8'h00, 32'h00000000};
      tbl[8]  = '{8'h85, 32'h00000000, 1'b0, 1'b0, 7'h00, 32'h00000000, 1'b1, 1'b0, 7'h00, 32'h00000000, 8'h00, 32'h00000000};
      tbl[9]  = '{8'h12, 32'h12345678, 1'b0, 1'b1, 7'h7F, 32'hA5A5A5A5, 1'b1, 1'b0, 7'h00, 32'h00000000, 8'h00, 32'h00000000};
      tbl[10] = '{8'h12, 32'h12345678, 1'b0, 1'b0, 7'h00, 32'h00000000, 1'b1, 1'b1, 7'h12, 32'h12345678, 8'hFF, 32'hA5A5A5A5};
      tbl[11] = '{8'h12, 32'h12345678, 1'b0, 1'b0, 7'h00, 32'h00000000, 1'b1, 1'b0, 7'h00, 32'h00000000, 8'hFF, 32'hA5A5A5A5};
      tbl[12] = '{8'h12, 32'h12345678, 1'b1, 1'b0, 7'h00, 32'h00000000, 1'b1, 1'b0, 7'h00, 32'h00000000, 8'hFF, 32'hA5A5A5A5};
      tbl[13] = '{8'h12, 32'h12345678, 1'b0, 1'b0, 7'h00, 32'h00000000, 1'b1, 1'b0, 7'h00, 32'h00000000, 8'h00, 32'h00000000};

      reset_n       = 1'b0;
      pio_send_addr = 8'h00;
      pio_send_data = 32'h0;
      pio_ack       = 1'b0;
      noc_tx_ready  = 1'b1;
      noc_rx_addr   = 7'h0;
      noc_rx_data   = 32'h0;
      noc_rx_valid  = 1'b0;
      cyc();
      cyc();
      chk_all("reset", 1'b0, 7'h00, 32'h0, 8'h00, 32'h0);
      reset_n = 1'b1;

      // Per-cycle vectors: drive, clock, compare.
      for (int i = 0; i < 14; i++) begin
         pio_send_addr = tbl[i].sa;
         pio_send_data = tbl[i].sd;
         pio_ack       = tbl[i].ack;
         noc_rx_valid  = tbl[i].rxv;
         noc_rx_addr   = tbl[i].rxa;
         noc_rx_data   = tbl[i].rxd;
         noc_tx_ready  = tbl[i].rdy;
         cyc();
         chk_all($sformatf("vec%0d", i), tbl[i].etv, tbl[i].eta, tbl[i].etd, tbl[i].era, tbl[i].erd);
      end
      pio_ack = 1'b0;

      // Backpressure: two held in order, third dropped.
      noc_tx_ready  = 1'b0;
      pio_send_data = 32'hA0000001; pio_send_addr = 8'h81; cyc();
      pio_send_data = 32'hA0000002; pio_send_addr = 8'h02; cyc();
      pio_send_data = 32'hA0000003; pio_send_addr = 8'h83; cyc();
      cyc();
      cyc();
      chk_all("bp_head1", 1'b1, 7'h01, 32'hA0000001, 8'h00, 32'h0);
      cyc();
      cyc();
      chk_all("bp_hold1", 1'b1, 7'h01, 32'hA0000001, 8'h00, 32'h0);
      noc_tx_ready = 1'b1;
      cyc();
      noc_tx_ready = 1'b0;
      chk_all("bp_head2", 1'b1, 7'h02, 32'hA0000002, 8'h00, 32'h0);
      cyc();
      cyc();
      chk_all("bp_hold2", 1'b1, 7'h02, 32'hA0000002, 8'h00, 32'h0);
      noc_tx_ready = 1'b1;
      cyc();
      noc_tx_ready = 1'b0;
      chk_all("bp_empty", 1'b0, 7'h00, 32'h0, 8'h00, 32'h0);
`ifdef NOC_ADAPTER_STATS_EN
      chk("bp_tx_drop", 32'(tx_drop_cnt), 32'd1);
`endif

      // RX overflow: nine strobes into eight entries.
      for (int i = 0; i < 9; i++) rx_strobe(7'h03, 32'(i));
      cyc();
      cyc();
      chk("fill_recv_addr", 32'(pio_recv_addr), 32'h83);
      chk("fill_recv_data", pio_recv_data, 32'h0);
`ifdef NOC_ADAPTER_STATS_EN
      chk("fill_rx_drop", 32'(rx_drop_cnt), 32'd1);
`endif

      // Drain with eight ack edges, then one on empty.
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("drain%0d_data", i), pio_recv_data, 32'(i));
         chk($sformatf("drain%0d_addr", i), 32'(pio_recv_addr), 32'h83);
         ack_pulse();
      end
      chk("drained_addr", 32'(pio_recv_addr), 32'h0);
      chk("drained_data", pio_recv_data, 32'h0);
      ack_pulse();
      cyc();
      chk("empty_ack_addr", 32'(pio_recv_addr), 32'h0);
      chk("empty_ack_data", pio_recv_data, 32'h0);

      // Full FIFO with push and pop landing on the same edge.
      for (int i = 0; i < 8; i++) rx_strobe(7'h04, 32'h100 + 32'(i));
      cyc();
      cyc();
      chk("sim_head0", pio_recv_data, 32'h100);
      pio_ack      = 1'b1;
      noc_rx_valid = 1'b1;
      noc_rx_addr  = 7'h55;
      noc_rx_data  = 32'h0000CAFE;
      cyc();
      pio_ack      = 1'b0;
      noc_rx_valid = 1'b0;
      cyc();
      for (int i = 1; i < 8; i++) begin
         chk($sformatf("sim_head%0d", i), pio_recv_data, 32'h100 + 32'(i));
         ack_pulse();
      end
      chk("sim_tail_data", pio_recv_data, 32'h0000CAFE);
      chk("sim_tail_addr", 32'(pio_recv_addr), 32'hD5);
      ack_pulse();
      chk("sim_empty", 32'(pio_recv_addr), 32'h0);
`ifdef NOC_ADAPTER_STATS_EN
      chk("sim_rx_drop", 32'(rx_drop_cnt), 32'd1);
`endif

      // Asynchronous reset with both buffers occupied.
      noc_tx_ready = 1'b0;
      rx_strobe(7'h02, 32'h77);
      rx_strobe(7'h02, 32'h78);
      pio_send_data = 32'hBEEF0001;
      pio_send_addr = 8'h06;
      cyc();
      cyc();
      cyc();
      chk_all("pre_reset", 1'b1, 7'h06, 32'hBEEF0001, 8'h82, 32'h77);
      reset_n = 1'b0;
      #1;
      chk_all("in_reset", 1'b0, 7'h00, 32'h0, 8'h00, 32'h0);
`ifdef NOC_ADAPTER_STATS_EN
      chk("in_reset_tx_drop", 32'(tx_drop_cnt), 32'd0);
      chk("in_reset_rx_drop", 32'(rx_drop_cnt), 32'd0);
`endif
      pio_send_addr = 8'h00;
      cyc();
      cyc();
      reset_n = 1'b1;
      cyc();
      cyc();
      cyc();
      chk_all("post_reset", 1'b0, 7'h00, 32'h0, 8'h00, 32'h0);
`ifdef NOC_ADAPTER_STATS_EN
      chk("post_reset_tx_drop", 32'(tx_drop_cnt), 32'd0);
      chk("post_reset_rx_drop", 32'(rx_drop_cnt), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
